// File: rtl/hospital_rover.sv
// hospital_rover: Moore FSM stepping a delivery rover around the fixed circuit
// Reception -> Ward -> ICU -> Pharmacy -> Reception. The rover advances one stop
// after move_switch has been sampled high for DWELL_CYCLES consecutive edges.
// Optional feature macro: ROVER_AUTO_HOME_EN (idle timeout returns the rover to
// Reception after HOME_TIMEOUT idle edges away from Reception).
module hospital_rover #(
  parameter int unsigned DWELL_CYCLES = 1,
  parameter int unsigned HOME_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_switch,
  output logic [3:0] current_loc
);

  typedef enum logic [3:0] {
    RECEPTION = 4'b0001,
    WARD      = 4'b0010,
    ICU       = 4'b0100,
    PHARMACY  = 4'b1000
  } state_t;

  localparam logic [7:0] DWELL_LIM = 8'(DWELL_CYCLES);

  // Reject out-of-range configurations at elaboration time.
  generate
    if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255 ||
        HOME_TIMEOUT < 1 || HOME_TIMEOUT > 255) begin : g_bad_params
      $error("hospital_rover: DWELL_CYCLES and HOME_TIMEOUT must be in 1..255");
    end
  endgenerate

  // The state register is plain logic so non-one-hot values (upsets) are
  // representable and recoverable.
  logic [3:0] state_q, state_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] dwell_inc;

`ifdef ROVER_AUTO_HOME_EN
  localparam logic [7:0] HOME_LIM = 8'(HOME_TIMEOUT);
  logic [7:0] idle_q, idle_d;
  logic [7:0] idle_inc;
`endif

  // Next stop on the forward-only circuit; Pharmacy wraps straight to Reception.
  function automatic logic [3:0] next_stop(input logic [3:0] s);
    case (s)
      RECEPTION: next_stop = WARD;
      WARD:      next_stop = ICU;
      ICU:       next_stop = PHARMACY;
      default:   next_stop = RECEPTION;
    endcase
  endfunction

  // True only for the four legal one-hot stop encodings.
  function automatic logic is_legal(input logic [3:0] s);
    case (s)
      RECEPTION, WARD, ICU, PHARMACY: is_legal = 1'b1;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

  // Next-state logic: dwell counting, advance, illegal-state recovery, idle return.
  always_comb begin
    state_d   = state_q;
    dwell_d   = '0;
    dwell_inc = dwell_q + 8'd1;
`ifdef ROVER_AUTO_HOME_EN
    idle_d    = '0;
    idle_inc  = idle_q + 8'd1;
`endif
    if (!is_legal(state_q)) begin
      state_d = RECEPTION;
    end else if (move_switch) begin
      if (dwell_inc == DWELL_LIM) begin
        state_d = next_stop(state_q);
      end else begin
        dwell_d = dwell_inc;
      end
    end else begin
`ifdef ROVER_AUTO_HOME_EN
      if (state_q != RECEPTION) begin
        if (idle_inc == HOME_LIM) begin
          state_d = RECEPTION;
        end else begin
          idle_d = idle_inc;
        end
      end
`endif
    end
  end

  // State and counter registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RECEPTION;
      dwell_q <= '0;
`ifdef ROVER_AUTO_HOME_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
`ifdef ROVER_AUTO_HOME_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign current_loc = state_q;

endmodule

// File: tb/tb_hospital_rover.sv
// Testbench for hospital_rover: two instances (DWELL_CYCLES=1 and 3) driven with
// directed sequences and random stimulus, compared against a stop-index model.
module tb_hospital_rover;

  logic       clk = 1'b0;
  logic       reset_a = 1'b1, move_a = 1'b0;
  logic       reset_b = 1'b1, move_b = 1'b0;
  logic [3:0] loc_a, loc_b;

  int checks   = 0;
  int failures = 0;

  // Reference model: stop index 0..3, consecutive-high run, idle run.
  int pos  [2];
  int cnt  [2];
  int idle [2];
  int dwell_of [2] = '{1, 3};
  localparam int HOME_T = 8;

  hospital_rover #(.DWELL_CYCLES(1), .HOME_TIMEOUT(HOME_T)) u_d1 (
    .clk(clk), .reset(reset_a), .move_switch(move_a), .current_loc(loc_a));

  hospital_rover #(.DWELL_CYCLES(3), .HOME_TIMEOUT(HOME_T)) u_d3 (
    .clk(clk), .reset(reset_b), .move_switch(move_b), .current_loc(loc_b));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] loc_of(input int k);
    return 4'(1 << pos[k]);
  endfunction

  task automatic model_edge(input int k, input logic r, input logic m);
    if (r) begin
      pos[k] = 0; cnt[k] = 0; idle[k] = 0;
    end else if (m === 1'b1) begin
      idle[k] = 0;
      cnt[k]++;
      if (cnt[k] == dwell_of[k]) begin
        pos[k] = (pos[k] + 1) % 4;
        cnt[k] = 0;
      end
    end else begin
      cnt[k] = 0;
`ifdef ROVER_AUTO_HOME_EN
      if (pos[k] != 0) begin
        idle[k]++;
        if (idle[k] == HOME_T) begin
          pos[k] = 0;
          idle[k] = 0;
        end
      end else begin
        idle[k] = 0;
      end
`endif
    end
  endtask

  // One clock edge on both instances, checked against the model.
  task automatic step(input string tag, input logic ra, input logic ma,
                      input logic rb, input logic mb);
    @(negedge clk);
    reset_a = ra; move_a = ma; reset_b = rb; move_b = mb;
    @(posedge clk);
    model_edge(0, ra, ma);
    model_edge(1, rb, mb);
    #1;
    check_eq({tag, "_d1"}, loc_a, loc_of(0));
    check_eq({tag, "_d3"}, loc_b, loc_of(1));
  endtask

  logic [3:0] lap_exp [5];

  initial begin
    lap_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};
    pos = '{0, 0}; cnt = '{0, 0}; idle = '{0, 0};

    // Reset, then idle edges stay at Reception.
    step("reset", 1, 0, 1, 0);
    check_eq("reset_const", loc_a, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step("idle_home", 0, 0, 0, 0);
      check_eq("idle_home_const", loc_a, 4'b0001);
    end

    // DWELL=1: three laps of 4 high / 1 low.
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 5; i++) begin
        step("lap", 0, (i < 4), 0, 0);
        check_eq("lap_const", loc_a, lap_exp[i]);
      end
    end

    // Reset beats move_switch while at ICU, then advance resumes.
    step("to_ward", 0, 1, 0, 0);
    step("to_icu", 0, 1, 0, 0);
    check_eq("at_icu", loc_a, 4'b0100);
    step("rst_prio", 1, 1, 1, 1);
    check_eq("rst_prio_const", loc_a, 4'b0001);
    step("resume", 0, 1, 0, 0);
    check_eq("resume_const", loc_a, 4'b0010);

    // DWELL=3: high 2, low 1, high 3 -> advance only on last edge.
    step("d3_rst", 1, 0, 1, 0);
    step("d3_h1", 0, 0, 0, 1);
    step("d3_h2", 0, 0, 0, 1);
    step("d3_l", 0, 0, 0, 0);
    step("d3_h1b", 0, 0, 0, 1);
    step("d3_h2b", 0, 0, 0, 1);
    check_eq("d3_no_adv", loc_b, 4'b0001);
    step("d3_h3b", 0, 0, 0, 1);
    check_eq("d3_adv", loc_b, 4'b0010);
    // Six more high edges -> exactly two advances.
    for (int i = 0; i < 6; i++) step("d3_hold", 0, 0, 0, 1);
    check_eq("d3_two_adv", loc_b, 4'b1000);

    // Illegal state recovery; DWELL=3 instance has a partial dwell that must clear.
    step("ill_pre", 1, 0, 1, 0);
    step("ill_pre_h1", 0, 0, 0, 1);
    step("ill_pre_h2", 0, 0, 0, 1);
    @(negedge clk);
    move_a = 1; move_b = 1; reset_a = 0; reset_b = 0;
    force u_d1.state_q = 4'b0110;
    force u_d3.state_q = 4'b0110;
    #1;
    release u_d1.state_q;
    release u_d3.state_q;
    @(posedge clk);
    pos = '{0, 0}; cnt = '{0, 0}; idle = '{0, 0};
    #1;
    check_eq("illegal_d1", loc_a, 4'b0001);
    check_eq("illegal_d3", loc_b, 4'b0001);
    step("ill_post_h1", 0, 1, 0, 1);
    step("ill_post_h2", 0, 0, 0, 1);
    check_eq("ill_dwell_clr", loc_b, 4'b0001);

    // Idle at ICU: auto-home after HOME_TIMEOUT edges if enabled, else hold.
    step("ah_rst", 1, 0, 1, 0);
    step("ah_w", 0, 1, 0, 0);
    step("ah_i", 0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step("autohome", 0, 0, 0, 0);
`ifdef ROVER_AUTO_HOME_EN
      check_eq("autohome_const", loc_a, (i < HOME_T) ? 4'b0100 : 4'b0001);
`else
      check_eq("hold_const", loc_a, 4'b0100);
`endif
    end

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
    end
    // Long idle bursts to exercise the idle path randomly.
    for (int i = 0; i < 200; i++) begin
      step("rand_idle", 1'b0, ($urandom_range(0, 9) == 0),
           1'b0, ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hospital_rover.md
Name: hospital_rover

Overview:
- Moore FSM that steps a hospital delivery rover around a fixed four-stop circuit.
- Stops: Reception → Ward → ICU → Pharmacy → Reception.
- Advances one stop when the operator's move switch is held for the dwell period; holds position otherwise.
- Sits between the operator switch-debounce logic and the location display/telemetry logic.

Parameters:
- DWELL_CYCLES, 1, consecutive clock edges move_switch must be sampled 1 before one advance; legal range 1..255.
- HOME_TIMEOUT, 8, idle edges before automatic return to Reception. Used only with ROVER_AUTO_HOME_EN; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- move_switch  input  1  operator request to move; 1 = move, 0 = stay.
- current_loc  output  4  one-hot current stop, registered.

Behaviour:
- One clock. Reset is synchronous and active-high. All state changes on the rising edge of clk.
- States and current_loc encoding (one-hot):
  - RECEPTION = 4'b0001
  - WARD = 4'b0010
  - ICU = 4'b0100
  - PHARMACY = 4'b1000
- current_loc is driven directly from the state register. No combinational path from move_switch to current_loc.
- Reset:
  - Sampled reset=1 → state RECEPTION (current_loc=4'b0001), dwell counter 0, idle counter 0.
  - Reset has priority over move_switch on the same edge, including mid-circuit.
- Dwell counter (8-bit):
  - Edge with move_switch==1 and counter+1 < DWELL_CYCLES → counter increments, state holds.
  - Edge with move_switch==1 and counter+1 == DWELL_CYCLES → state advances one stop, counter clears.
  - Edge with move_switch!=1 → counter clears, state holds.
  - Only a sampled 1 counts; 0, X or Z hold the state (plain if on move_switch).
- DWELL_CYCLES=1: the rover advances on every edge where move_switch==1.
- Latency: current_loc changes on the edge that completes the dwell.
- Transitions, in order: RECEPTION→WARD→ICU→PHARMACY→RECEPTION. PHARMACY wraps to RECEPTION with no extra cycle.
- Direction is forward only. There is no reverse.
- Illegal state (any non-one-hot value, e.g. from an SEU) → RECEPTION on the next edge, regardless of move_switch. The dwell counter clears on that edge.
- Toggling move_switch never skips stops; at most one advance per edge.

Optional Feature:
- Macro ROVER_AUTO_HOME_EN.
- Defined:
  - 8-bit idle counter increments on each edge where move_switch!=1 and state!=RECEPTION.
  - On the edge where the idle count reaches HOME_TIMEOUT, state → RECEPTION and the idle counter clears.
  - Any edge with move_switch==1, or state RECEPTION, clears the idle counter.
  - Reset clears the idle counter.
- Not defined: no idle counter in the netlist; the rover holds its stop indefinitely while move_switch is 0.

Test Plan:
1. Reset, then move_switch=0 for 3 edges → current_loc stays 4'b0001 throughout.
2. DWELL_CYCLES=1, reset, move_switch=1 for 4 edges → current_loc 0010, 0100, 1000, 0001. Then move_switch=0 for 1 edge → stays 0001. Repeat the 4-high/1-low pattern three times → identical sequence each lap.
3. From ICU (0100), assert reset together with move_switch=1 → 0001 on that edge. Then advance resumes 0010 on the next high edge.
4. DWELL_CYCLES=3:
   - move_switch high 2 edges, low 1 edge, high 3 edges → first advance (0001→0010) only on the 3rd high edge of the second burst.
   - Holding move_switch high for 6 edges → exactly 2 advances.
5. Force state to 4'b0110, move_switch=1 → next edge current_loc=0001.
6. With ROVER_AUTO_HOME_EN, HOME_TIMEOUT=8: advance to ICU, then move_switch=0 → 0100 for 7 edges, 0001 on the 8th. Without the macro, it stays 0100 for 20 edges.
